// File: rtl/gpmc_wb_pkg.sv
// Shared types and constants for the GPMC-to-Wishbone bridge.
// Holds the FSM encoding, the error fill pattern and the default timeout.
package gpmc_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WB_WR,
        ST_WB_RD,
        ST_DONE
    } state_t;

    // Read data returned to the host when a read ends in err or timeout.
    localparam logic [63:0] ERR_FILL = '1;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/gpmc_wb_bridge_if.sv
// Wishbone master bus driven by the GPMC bridge.
// The master modport is the bridge side; the slave modport is the interconnect side.
interface gpmc_wb_bridge_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
);

    logic [ADDR_WIDTH-1:0] wbm_address;
    logic [DATA_WIDTH-1:0] wbm_writedata;
    logic [DATA_WIDTH-1:0] wbm_readdata;
    logic                  wbm_write;
    logic                  wbm_strobe;
    logic                  wbm_cycle;
    logic                  wbm_ack;
    logic                  wbm_err;

    modport master (
        output wbm_address, wbm_writedata, wbm_write, wbm_strobe, wbm_cycle,
        input  wbm_readdata, wbm_ack, wbm_err
    );

    modport slave (
        input  wbm_address, wbm_writedata, wbm_write, wbm_strobe, wbm_cycle,
        output wbm_readdata, wbm_ack, wbm_err
    );

endinterface

// File: rtl/gpmc_sync.sv
// Vectored multi-stage synchroniser for the asynchronous GPMC pins.
// Each bit resets to its own idle value so the FSM never sees a phantom cycle.
module gpmc_sync #(
    parameter int              WIDTH     = 1,
    parameter int              STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        // NOTE: every stage of the chain is reset, not just the last, so idle
        // values are what the FSM sees for the whole refill after reset.
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gpmc_wb_bridge.sv
// GPMC slave to Wishbone master bridge with per-chip-select regions,
// host stall via WAIT, and sticky timeout / bus-error flags.
module gpmc_wb_bridge
    import gpmc_wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CS      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
    output logic [DATA_WIDTH-1:0] gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    input  logic [NUM_CS-1:0]     gpmc_csn,
    input  logic                  gpmc_advn,
    input  logic                  gpmc_wein,
    input  logic                  gpmc_oen,
    output logic                  gpmc_wait,
    gpmc_wb_bridge_if.master      wb,
    output logic                  timeout_err,
    output logic                  bus_err,
    input  logic                  err_clear
);

    localparam int CS_BITS = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int SW      = DATA_WIDTH + NUM_CS + 3;
    localparam logic [SW-1:0] SYNC_IDLE = {{DATA_WIDTH{1'b0}}, {NUM_CS{1'b1}}, 3'b111};

    logic [SW-1:0]         sync_q;
    logic [DATA_WIDTH-1:0] ad_s;
    logic [NUM_CS-1:0]     csn_s;
    logic                  advn_s, wein_s, oen_s;

    gpmc_sync #(.WIDTH(SW), .STAGES(SYNC_STAGES), .RESET_VAL(SYNC_IDLE)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({gpmc_ad_in, gpmc_csn, gpmc_advn, gpmc_wein, gpmc_oen}),
        .q     (sync_q)
    );

    assign {ad_s, csn_s, advn_s, wein_s, oen_s} = sync_q;

    state_t                state, state_next;
    logic [CS_BITS-1:0]    cs_idx, first_cs;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [CNT_W-1:0]      cnt;
    logic                  is_read;
    logic                  sel_csn, wb_active, cnt_last;
    logic                  ev_ack, ev_err, ev_tmo;

    assign sel_csn  = csn_s[cs_idx];
    assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

    // Lowest-numbered asserted chip select wins when several are low.
    always_comb begin
        first_cs = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (!csn_s[i]) first_cs = CS_BITS'(i);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        wb_active  = 1'b0;
        gpmc_wait  = 1'b0;
        gpmc_ad_oe = 1'b0;
        ev_ack     = 1'b0;
        ev_err     = 1'b0;
        ev_tmo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!(&csn_s) && !advn_s) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (sel_csn)              state_next = ST_IDLE;
                else if (advn_s && !wein_s) state_next = ST_WB_WR;
                else if (advn_s && !oen_s)  state_next = ST_WB_RD;
            end
            ST_WB_WR, ST_WB_RD: begin
                wb_active = 1'b1;
                gpmc_wait = 1'b1;
                ev_err    = wb.wbm_err;
                ev_ack    = wb.wbm_ack && !wb.wbm_err;
                ev_tmo    = cnt_last && !wb.wbm_ack && !wb.wbm_err;
                if (ev_ack || ev_err || ev_tmo) state_next = ST_DONE;
            end
            ST_DONE: begin
                gpmc_ad_oe = is_read && !sel_csn && !oen_s;
                if (sel_csn) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // samples the pre-edge value of every other one.
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cs_idx      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            is_read     <= 1'b0;
            timeout_err <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= wb_active ? cnt + 1'b1 : '0;
            if (state == ST_IDLE && state_next == ST_ADDR) begin
                addr_q <= ad_s[ADDR_WIDTH-1:0];
                cs_idx <= first_cs;
            end
            if (state == ST_ADDR) is_read <= (state_next == ST_WB_RD);
            if (state == ST_ADDR && state_next == ST_WB_WR) wdata_q <= ad_s;
            if (state == ST_WB_RD && ev_ack) rdata_q <= wb.wbm_readdata;
            else if (state == ST_WB_RD && (ev_err || ev_tmo)) rdata_q <= ERR_FILL[DATA_WIDTH-1:0];
            // A fresh error in the same cycle as err_clear stays set.
            timeout_err <= (timeout_err && !err_clear) || ev_tmo;
            bus_err     <= (bus_err && !err_clear) || ev_err;
        end
    end

    assign wb.wbm_address   = {cs_idx, addr_q};
    assign wb.wbm_writedata = wdata_q;
    assign wb.wbm_write     = (state == ST_WB_WR);
    assign wb.wbm_cycle     = wb_active;
    assign wb.wbm_strobe    = wb_active;
    assign gpmc_ad_out      = rdata_q;

endmodule

// File: tb/tb_gpmc_wb_bridge.sv
// Directed self-checking bench for gpmc_wb_bridge (2 chip selects, TIMEOUT=8).
// The bench plays both the GPMC host and the Wishbone slave.
module tb_gpmc_wb_bridge;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] ad_in;
    logic [DW-1:0] ad_out;
    logic          ad_oe;
    logic [1:0]    csn;
    logic          advn, wein, oen;
    logic          gpmc_wait;
    logic          timeout_err, bus_err;
    logic          err_clear;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpmc_wb_bridge_if #(.ADDR_WIDTH(AW + 1), .DATA_WIDTH(DW)) bus ();

    gpmc_wb_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CS(2), .SYNC_STAGES(2), .TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gpmc_ad_in  (ad_in),
        .gpmc_ad_out (ad_out),
        .gpmc_ad_oe  (ad_oe),
        .gpmc_csn    (csn),
        .gpmc_advn   (advn),
        .gpmc_wein   (wein),
        .gpmc_oen    (oen),
        .gpmc_wait   (gpmc_wait),
        .wb          (bus),
        .timeout_err (timeout_err),
        .bus_err     (bus_err),
        .err_clear   (err_clear)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic addr_phase(input logic [1:0] cs, input logic [DW-1:0] addr);
        csn   = cs;
        advn  = 1'b0;
        ad_in = addr;
        cycles(3);
    endtask

    task automatic host_idle();
        csn   = 2'b11;
        advn  = 1'b1;
        wein  = 1'b1;
        oen   = 1'b1;
        ad_in = '0;
        cycles(4);
    endtask

    // Bounded poll for the start of a Wishbone cycle; returns on the first
    // negedge where cyc is seen high.
    task automatic wait_cyc(input string tag);
        int n = 0;
        while (!bus.wbm_cycle && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.wbm_cycle), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_wait, n_cyc;

        reset            = 1'b1;
        csn              = 2'b11;
        advn             = 1'b1;
        wein             = 1'b1;
        oen              = 1'b1;
        ad_in            = '0;
        err_clear        = 1'b0;
        bus.wbm_ack      = 1'b0;
        bus.wbm_err      = 1'b0;
        bus.wbm_readdata = '0;
        cycles(4);

        check("rst_cyc",     32'(bus.wbm_cycle),  32'h0);
        check("rst_stb",     32'(bus.wbm_strobe), 32'h0);
        check("rst_we",      32'(bus.wbm_write),  32'h0);
        check("rst_addr",    32'(bus.wbm_address), 32'h0);
        check("rst_wait",    32'(gpmc_wait),      32'h0);
        check("rst_oe",      32'(ad_oe),          32'h0);
        check("rst_ad_out",  32'(ad_out),         32'h0);
        check("rst_flags",   32'({timeout_err, bus_err}), 32'h0);
        reset = 1'b0;
        cycles(2);

        // Write cs0 0x0012 <- 0xBEEF, slave acks in the 4th cycle
        addr_phase(2'b10, 16'h0012);
        advn  = 1'b1;
        wein  = 1'b0;
        ad_in = 16'hBEEF;
        wait_cyc("wr_start");
        check("wr_addr",  32'(bus.wbm_address),   32'h0_0012);
        check("wr_data",  32'(bus.wbm_writedata), 32'hBEEF);
        check("wr_we",    32'(bus.wbm_write),     32'h1);
        check("wr_stb",   32'(bus.wbm_strobe),    32'h1);
        n_wait = 0;
        n_cyc  = 0;
        for (int k = 0; k < 10; k++) begin
            if (gpmc_wait) n_wait++;
            if (bus.wbm_cycle) n_cyc++;
            bus.wbm_ack = (k == 3);
            @(negedge clk);
        end
        bus.wbm_ack = 1'b0;
        check("wr_wait_len", 32'(n_wait), 32'd4);
        check("wr_cyc_len",  32'(n_cyc),  32'd4);
        check("wr_wait_end", 32'(gpmc_wait), 32'h0);
        check("wr_flags",    32'({timeout_err, bus_err}), 32'h0);
        host_idle();

        // Read cs1 0x0040, zero-wait ack with 0x1234
        addr_phase(2'b01, 16'h0040);
        advn  = 1'b1;
        oen   = 1'b0;
        ad_in = '0;
        wait_cyc("rd_start");
        check("rd_addr", 32'(bus.wbm_address), 32'h1_0040);
        check("rd_we",   32'(bus.wbm_write),   32'h0);
        check("rd_wait", 32'(gpmc_wait),       32'h1);
        bus.wbm_ack      = 1'b1;
        bus.wbm_readdata = 16'h1234;
        @(negedge clk);
        bus.wbm_ack      = 1'b0;
        bus.wbm_readdata = '0;
        check("rd_cyc_once", 32'(bus.wbm_cycle), 32'h0);
        check("rd_data",     32'(ad_out),        32'h1234);
        check("rd_oe",       32'(ad_oe),         32'h1);
        check("rd_wait_end", 32'(gpmc_wait),     32'h0);
        oen = 1'b1;
        cycles(3);
        check("rd_oe_off",   32'(ad_oe),         32'h0);
        host_idle();

        // Read with no ack: times out after 8 cycles
        addr_phase(2'b10, 16'h0005);
        advn = 1'b1;
        oen  = 1'b0;
        wait_cyc("to_start");
        n_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.wbm_cycle) n_cyc++;
            @(negedge clk);
        end
        check("to_cyc_len", 32'(n_cyc),       32'd8);
        check("to_flag",    32'(timeout_err), 32'h1);
        check("to_fill",    32'(ad_out),      32'hFFFF);
        check("to_bus_err", 32'(bus_err),     32'h0);
        host_idle();
        check("to_sticky",  32'(timeout_err), 32'h1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("to_cleared", 32'(timeout_err), 32'h0);

        // Write with ack and err together; err_clear in the same cycle
        addr_phase(2'b01, 16'h0077);
        advn  = 1'b1;
        wein  = 1'b0;
        ad_in = 16'h5555;
        wait_cyc("ae_start");
        check("ae_addr", 32'(bus.wbm_address), 32'h1_0077);
        bus.wbm_ack = 1'b1;
        bus.wbm_err = 1'b1;
        err_clear   = 1'b1;
        @(negedge clk);
        bus.wbm_ack = 1'b0;
        bus.wbm_err = 1'b0;
        err_clear   = 1'b0;
        check("ae_bus_err", 32'(bus_err),       32'h1);
        check("ae_to_err",  32'(timeout_err),   32'h0);
        check("ae_wait",    32'(gpmc_wait),     32'h0);
        n_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.wbm_cycle) n_cyc++;
            @(negedge clk);
        end
        check("ae_no_dup",  32'(n_cyc),  32'd0);
        check("ae_keep_rd", 32'(ad_out), 32'hFFFF);
        host_idle();
        check("ae_idle_cyc", 32'(bus.wbm_cycle), 32'h0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("ae_cleared", 32'(bus_err), 32'h0);

        // Reset in the middle of a read
        addr_phase(2'b10, 16'h0033);
        advn = 1'b1;
        oen  = 1'b0;
        wait_cyc("rr_start");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rr_cyc",    32'(bus.wbm_cycle),  32'h0);
        check("rr_stb",    32'(bus.wbm_strobe), 32'h0);
        check("rr_wait",   32'(gpmc_wait),      32'h0);
        check("rr_oe",     32'(ad_oe),          32'h0);
        check("rr_ad_out", 32'(ad_out),         32'h0);
        csn  = 2'b11;
        advn = 1'b1;
        oen  = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(2);

        // Normal write after reset, zero-wait ack
        addr_phase(2'b10, 16'h0021);
        advn  = 1'b1;
        wein  = 1'b0;
        ad_in = 16'hA5A5;
        wait_cyc("pr_start");
        check("pr_addr", 32'(bus.wbm_address),   32'h0_0021);
        check("pr_data", 32'(bus.wbm_writedata), 32'hA5A5);
        bus.wbm_ack = 1'b1;
        @(negedge clk);
        bus.wbm_ack = 1'b0;
        check("pr_cyc_once", 32'(bus.wbm_cycle), 32'h0);
        check("pr_wait",     32'(gpmc_wait),     32'h0);
        host_idle();

        // Both chip selects low: cs0 wins
        addr_phase(2'b00, 16'h0099);
        advn = 1'b1;
        oen  = 1'b0;
        wait_cyc("cs_start");
        check("cs_region", 32'(bus.wbm_address), 32'h0_0099);
        bus.wbm_ack      = 1'b1;
        bus.wbm_readdata = 16'hCAFE;
        @(negedge clk);
        bus.wbm_ack      = 1'b0;
        bus.wbm_readdata = '0;
        check("cs_data", 32'(ad_out), 32'hCAFE);
        check("cs_oe",   32'(ad_oe),  32'h1);
        host_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpmc_wb_bridge.md
# gpmc_wb_bridge

Parametrised GPMC-to-Wishbone master bridge, single clock domain, sitting between the BeagleBone GPMC pins (via top-level SB_IO tristate cells) and the FPGA Wishbone interconnect. It supports multiple chip selects mapped to separate Wishbone regions. It runs a full Wishbone handshake that waits for ack, with a GPMC WAIT output that stalls the host. It provides timeout and bus-error reporting.

## Interface
- ADDR_WIDTH, 16, address bits latched from the AD bus per chip select; must be ≤ DATA_WIDTH
- DATA_WIDTH, 16, GPMC AD / Wishbone data width
- NUM_CS, 2, number of GPMC chip selects handled (≥1)
- SYNC_STAGES, 2, synchroniser depth applied to all GPMC inputs (≥2)
- TIMEOUT, 255, maximum clk cycles a Wishbone cycle may wait for ack/err
- CS_BITS, derived $clog2(NUM_CS) (min 1), region-select bits

Ports:
- clk  in  1  FPGA clock; all logic on posedge
- reset  in  1  synchronous, active-high
- gpmc_ad_in  in  DATA_WIDTH  AD pin input (from SB_IO D_IN_0)
- gpmc_ad_out  out  DATA_WIDTH  read data to AD pins (registered)
- gpmc_ad_oe  out  1  AD pin output enable
- gpmc_csn  in  NUM_CS  chip selects, active low
- gpmc_advn  in  1  low = address phase
- gpmc_wein  in  1  low = write
- gpmc_oen  in  1  low = read
- gpmc_wait  out  1  high = host must stall
- wbm_address  out  ADDR_WIDTH+CS_BITS  {cs index, latched address}
- wbm_writedata  out  DATA_WIDTH  write data
- wbm_readdata  in  DATA_WIDTH  slave read data
- wbm_write  out  1  high = write cycle
- wbm_strobe  out  1  valid transfer
- wbm_cycle  out  1  cycle in progress
- wbm_ack  in  1  slave acknowledge
- wbm_err  in  1  slave error
- timeout_err  out  1  sticky: a cycle timed out
- bus_err  out  1  sticky: a slave returned err
- err_clear  in  1  clears both sticky flags

## Operation
- All GPMC inputs, including AD, pass through the same SYNC_STAGES flops. The FSM sees only synchronised values.
- FSM states: IDLE, ADDR, WB_WR, WB_RD, DONE.
- IDLE: when any csn is low and advn is low, latch AD[ADDR_WIDTH-1:0] and the index of the lowest-numbered low csn, then go to ADDR.
- ADDR: if the selected csn rises, go to IDLE. Once advn is high: wein low → capture AD into the write register and go to WB_WR; else oen low → go to WB_RD. If both are low, write wins.
- WB_WR/WB_RD: cyc=stb=1, we=1 only in WB_WR, gpmc_wait=1. The timeout counter increments each cycle in these states.
  - ack → go to DONE; a read also latches wbm_readdata.
  - err → go to DONE and set bus_err; a read returns all-ones.
  - counter reaching TIMEOUT → drop cyc/stb, set timeout_err, return all-ones, go to DONE.
  - If ack and err arrive together, err takes priority.
- DONE: gpmc_wait=0. gpmc_ad_oe=1 iff this was a read and csn and oen are still low. Go to IDLE when the selected csn is high.
- Host deasserting csn during WB_WR/WB_RD does not abort the Wishbone cycle; it completes and DONE exits on the next cycle.
- err_clear clears both sticky flags. If a new error is set in the same cycle, set wins.
- reset: FSM→IDLE; synchronisers filled with idle values (csn/advn/wein/oen high); counter cleared.

## Timing
- Reset values of all outputs are 0, except gpmc_wait=0 and gpmc_ad_oe=0. gpmc_ad_out resets to 0.
- Pin-to-FSM latency: SYNC_STAGES cycles.
- Wishbone cyc/stb assert in the cycle after the FSM leaves ADDR; wait asserts in the same cycle.
- Read: gpmc_ad_out is valid in the cycle after ack. gpmc_wait falls in that same cycle.
- Zero-wait slave (ack in first cycle): cyc/stb high for exactly 1 cycle.
- The host must hold write data stable for ≥ SYNC_STAGES+1 cycles after wein falls.
- A new transaction requires the selected csn high for ≥1 synchronised cycle (via DONE→IDLE).

## Structure
- Package gpmc_wb_pkg: FSM state enum, ERR_FILL constant (all-ones), default TIMEOUT.
- Sub-module gpmc_sync: vectored SYNC_STAGES-deep synchroniser with per-bit reset value, one instance for all GPMC inputs.
- SB_IO instantiation stays at top level; this block exposes in/out/oe only.

## Test plan
- Write cs0 addr 0x0012 data 0xBEEF, ack after 3 cycles → wbm_address=0x0_0012, writedata=0xBEEF, we=1, wait high 4 cycles then low.
- Read cs1 addr 0x0040, slave returns 0x1234 with same-cycle ack → wbm_address MSB=1, gpmc_ad_out=0x1234, oe=1 while oen low.
- Read with no ack, TIMEOUT=8 → cyc drops after 8 cycles, gpmc_ad_out=0xFFFF, timeout_err=1 until err_clear.
- Write with ack and err asserted together → bus_err=1, no duplicate cycle, FSM→DONE→IDLE.
- Reset asserted mid WB_RD → next cycle cyc/stb/wait/oe=0, state IDLE; next transaction completes normally.
- Both csn low in address phase → cs0 selected, wbm_address region bit=0.
